// File: rtl/regfile_wb_arbiter.sv
// Write-back controller for a 32x32 register file: round-robin write-port arbiter,
// pending-write scoreboard (RAW/WAW stalls). Optional bypass: define REGARB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int NREQ  = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [5*NREQ-1:0]   req_wr,
    input  logic [32*NREQ-1:0]  req_wd,
    output logic [NREQ-1:0]     req_ready,
    output logic                reg_write,
    output logic [4:0]          wr,
    output logic [31:0]         wd,
    input  logic                issue_valid,
    input  logic [4:0]          issue_rd,
    output logic                issue_stall,
    input  logic [4:0]          rr_1,
    input  logic [4:0]          rr_2,
    output logic                raw_stall,
    output logic                byp_hit_1,
    output logic                byp_hit_2,
    output logic [31:0]         byp_data,
    output logic [CNT_W-1:0]    wb_count
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       wr_q, wr_d;
    logic [31:0]      wd_q, wd_d;
    logic [31:0]      pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             grant_vld_s;
    logic [PTR_W-1:0] grant_idx_s;
    logic [4:0]       sel_wr_s;
    logic [31:0]      sel_wd_s;
    logic             issue_set_s;
    logic             op1_pend_s;
    logic             op2_pend_s;
    logic             byp1_s;
    logic             byp2_s;

    // Round-robin scan: first valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int idx_v;
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        idx_v       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_v = (int'(rr_ptr_q) + k) % NREQ;
            if (!grant_vld_s && req_valid[idx_v]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = PTR_W'(idx_v);
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // One-hot ready plus the winning requester's address/data.
    always_comb begin
        req_ready = '0;
        sel_wr_s  = req_wr[5*int'(grant_idx_s) +: 5];
        sel_wd_s  = req_wd[32*int'(grant_idx_s) +: 32];
        if (grant_vld_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Output stage next state; register 0 writes handshake but never enable the port.
    always_comb begin
        reg_write_d = 1'b0;
        wr_d        = wr_q;
        wd_d        = wd_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant_vld_s) begin
            wr_d        = sel_wr_s;
            wd_d        = sel_wd_s;
            reg_write_d = (sel_wr_s != 5'd0);
            if (int'(grant_idx_s) == NREQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx_s + PTR_W'(1);
            end
        end else begin
            reg_write_d = 1'b0;
        end
    end

    assign issue_stall = issue_valid && (issue_rd != 5'd0) && pend_q[issue_rd];
    assign issue_set_s = issue_valid && (issue_rd != 5'd0) && !pend_q[issue_rd];

    // Scoreboard next state: clear on commit first so a same-cycle set wins.
    always_comb begin
        pend_d = pend_q;
        if (reg_write_q && (wr_q != 5'd0)) begin
            pend_d[wr_q] = 1'b0;
        end else begin
            pend_d = pend_d;
        end
        if (issue_set_s) begin
            pend_d[issue_rd] = 1'b1;
        end else begin
            pend_d = pend_d;
        end
    end

    // Saturating count of committed writes.
    always_comb begin
        cnt_d = cnt_q;
        if (reg_write_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            reg_write_q <= 1'b0;
            wr_q        <= 5'd0;
            wd_q        <= 32'd0;
            pend_q      <= 32'd0;
            cnt_q       <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            reg_write_q <= reg_write_d;
            wr_q        <= wr_d;
            wd_q        <= wd_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
        end
    end

    assign op1_pend_s = (rr_1 != 5'd0) && pend_q[rr_1];
    assign op2_pend_s = (rr_2 != 5'd0) && pend_q[rr_2];

`ifdef REGARB_BYPASS_EN
    // A write being presented this cycle can feed the reader directly.
    assign byp1_s   = reg_write_q && (wr_q == rr_1) && (rr_1 != 5'd0);
    assign byp2_s   = reg_write_q && (wr_q == rr_2) && (rr_2 != 5'd0);
    assign byp_data = wd_q;
`else
    assign byp1_s   = 1'b0;
    assign byp2_s   = 1'b0;
    assign byp_data = 32'd0;
`endif

    assign byp_hit_1 = byp1_s;
    assign byp_hit_2 = byp2_s;
    assign raw_stall = (op1_pend_s && !byp1_s) || (op2_pend_s && !byp2_s);

    assign reg_write = reg_write_q;
    assign wr        = wr_q;
    assign wd        = wd_q;
    assign wb_count  = cnt_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back controller for the 32x32 register file. It shares the file's single write port (wr/wd/reg_write) among NREQ producers using round-robin arbitration. It also keeps a 32-entry pending-write scoreboard that drives RAW stalls on the two read ports and WAW stalls at issue.

Parameters:
NREQ, 2, number of write-back requesters (2..4)
CNT_W, 16, width of the committed-write counter

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester write request
req_wr  in  5*NREQ  destination register; requester i uses bits [5i+4:5i]
req_wd  in  32*NREQ  write data; requester i uses bits [32i+31:32i]
req_ready  out  NREQ  one-hot grant; handshake completes when valid&ready
reg_write  out  1  regfile write enable (registered)
wr  out  5  regfile write address (registered)
wd  out  32  regfile write data (registered)
issue_valid  in  1  instruction issuing that will write issue_rd
issue_rd  in  5  destination of the issuing instruction
issue_stall  out  1  WAW stall; the issue is not recorded this cycle
rr_1  in  5  read address 1, observed from the regfile read port
rr_2  in  5  read address 2, observed from the regfile read port
raw_stall  out  1  a read operand has a pending write
byp_hit_1  out  1  bypass valid for rr_1 (optional feature)
byp_hit_2  out  1  bypass valid for rr_2 (optional feature)
byp_data  out  32  bypass data (optional feature)
wb_count  out  CNT_W  saturating count of committed non-zero writes

Behaviour:
- Reset (async, rst_n=0):
  - reg_write=0, wr=0, wd=0.
  - Scoreboard pend[31:0]=0, rr_ptr=0, wb_count=0.
  - Any in-flight request is dropped.
- Arbitration (combinational):
  - Scan req_valid starting at rr_ptr, wrapping modulo NREQ; the first valid requester g gets req_ready[g]=1.
  - At most one ready bit is high. req_ready=0 when no request is valid.
  - The output stage accepts every cycle, so there is no backpressure beyond the arbitration loss.
- On accept at posedge:
  - rr_ptr <= (g+1) mod NREQ.
  - wr <= req_wr[g], wd <= req_wd[g].
  - reg_write <= (req_wr[g] != 0).
- With no accept, reg_write <= 0; wr/wd hold their last values.
- Latency: one cycle from handshake to reg_write; the regfile captures the write at the following posedge.
- Register 0 writes complete the handshake but never assert reg_write, never touch pend, and do not count.
- Scoreboard:
  - Set: issue_valid && issue_rd!=0 && !issue_stall sets pend[issue_rd].
  - Clear: at any posedge with reg_write=1, pend[wr] is cleared.
  - Same register set and cleared in one cycle: set wins.
- issue_stall = issue_valid && issue_rd!=0 && pend[issue_rd] (combinational). The issue retries in a later cycle.
- raw_stall (combinational) = (rr_1!=0 && pend[rr_1]) || (rr_2!=0 && pend[rr_2]).
  - Without bypass, raw_stall stays high during the cycle reg_write presents the register.
- wb_count increments at each posedge with reg_write=1 and saturates at all-ones.
- Requests for an unissued (not pending) register are legal and written normally; the scoreboard is unaffected apart from the clear.
- A requester holding valid while not granted must keep req_wr/req_wd stable.

Optional Feature:
REGARB_BYPASS_EN
- Defined:
  - byp_hit_k = reg_write && wr==rr_k && rr_k!=0.
  - byp_data = wd.
  - raw_stall ignores operand k when byp_hit_k, so the consumer proceeds using byp_data.
- Undefined: byp_hit_1, byp_hit_2 and byp_data are tied 0; raw_stall is as in Behaviour.

Test Plan:
- Reset mid-write: assert rst_n=0 while reg_write=1, wr=5 -> same cycle reg_write=0, wr=0, wd=0, pend=0, wb_count=0.
- Round-robin: both requesters valid continuously, NREQ=2 -> grants alternate 0,1,0,1 starting at 0; one req_ready per cycle; reg_write one cycle after each handshake.
- Scoreboard: issue rd=7, then read rr_1=7 -> raw_stall=1; requester writes r7=0xDEADBEEF -> pend[7] clears at the posedge with reg_write=1, wr=7; raw_stall=0 the next cycle.
- WAW plus same-cycle set/clear: pend[3]=1, issue rd=3 -> issue_stall=1; in the cycle reg_write clears r3 while a new issue of rd=3 arrives, the issue is stalled (pend still 1); the retry next cycle sets pend[3]=1.
- Register 0: request wr=0, wd=0x1234 -> handshake completes, reg_write stays 0, wb_count unchanged; issue rd=0 never stalls.
- REGARB_BYPASS_EN: pend[9]=1, reg_write=1, wr=9, wd=0xA5A5A5A5, rr_2=9 -> byp_hit_2=1, byp_data=0xA5A5A5A5, raw_stall=0; with the macro undefined, raw_stall=1.
